ram_arbiter: RTL and testbench

Two-requester round-robin arbiter and sequencer for the single-port parity RAM (`ram`, MEM_WIDTH=16, 1024 deep, ADDR_PIPELINE="FALSE", DOUT_PIPELINE="TRUE"). It accepts read/write commands from requesters A and B and issues at most one registered command per cycle to the RAM. It tags each read so the returned data is routed to the right requester. It also checks the RAM's parity output on every returned word.

---
 rtl/ram_arb_pkg.sv | 19 +
 rtl/ram_rd_tag_pipe.sv | 32 +++
 rtl/ram_arbiter.sv | 109 ++++++++++
 tb/tb_ram_arbiter.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/ram_arb_pkg.sv
// Shared types and default sizing for the two-requester parity-RAM arbiter.
package ram_arb_pkg;

    localparam int DEF_MEM_WIDTH  = 16;
    localparam int DEF_ADDR_SIZE  = 10;
    localparam int DEF_RD_LATENCY = 2;

    typedef enum logic {
        REQ_A = 1'b0,
        REQ_B = 1'b1
    } req_id_t;

    typedef struct packed {
        logic                     we;
        logic [DEF_ADDR_SIZE-1:0] addr;
        logic [DEF_MEM_WIDTH-1:0] wdata;
    } ram_cmd_t;

endpackage

// File: rtl/ram_rd_tag_pipe.sv
// Shift register of {valid, id} read tags that tracks reads in flight through the RAM.
module ram_rd_tag_pipe
    import ram_arb_pkg::*;
#(
    parameter int DEPTH = 3
) (
    input  logic    clk,
    input  logic    rst,
    input  logic    push_valid,
    input  req_id_t push_id,
    output logic    tag_valid,
    output req_id_t tag_id
);

    logic [DEPTH-1:0] valid_sr;
    req_id_t          id_sr [DEPTH];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_sr <= '0;
            for (int i = 0; i < DEPTH; i++) id_sr[i] <= REQ_A;
        end else begin
            valid_sr <= {valid_sr[DEPTH-2:0], push_valid};
            id_sr[0] <= push_id;
            for (int i = 1; i < DEPTH; i++) id_sr[i] <= id_sr[i-1];
        end
    end

    assign tag_valid = valid_sr[DEPTH-1];
    assign tag_id    = id_sr[DEPTH-1];

endmodule

// File: rtl/ram_arbiter.sv
// Round-robin arbiter and registered command stage for a single-port parity RAM,
// with read-return routing and a sticky parity checker.
module ram_arbiter
    import ram_arb_pkg::*;
#(
    parameter int MEM_WIDTH  = DEF_MEM_WIDTH,
    parameter int ADDR_SIZE  = DEF_ADDR_SIZE,
    parameter int RD_LATENCY = DEF_RD_LATENCY
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 a_req,
    input  logic                 a_we,
    input  logic [ADDR_SIZE-1:0] a_addr,
    input  logic [MEM_WIDTH-1:0] a_wdata,
    input  logic                 b_req,
    input  logic                 b_we,
    input  logic [ADDR_SIZE-1:0] b_addr,
    input  logic [MEM_WIDTH-1:0] b_wdata,
    output logic                 a_gnt,
    output logic                 b_gnt,
    output logic                 rd_valid,
    output logic                 rd_id,
    output logic [MEM_WIDTH-1:0] rd_data,
    output logic                 parity_err,
    output logic                 ram_blk_select,
    output logic                 ram_wr_en,
    output logic                 ram_rd_en,
    output logic [ADDR_SIZE-1:0] ram_addr,
    output logic [MEM_WIDTH-1:0] ram_din,
    output logic                 ram_addr_en,
    output logic                 ram_dout_en,
    input  logic [MEM_WIDTH-1:0] ram_dout,
    input  logic                 ram_parity
);

    // last_b=1 means B was granted most recently; reset value lets A win first contention.
    logic                 last_b;
    logic                 any_gnt;
    logic                 win_we;
    logic [ADDR_SIZE-1:0] win_addr;
    logic [MEM_WIDTH-1:0] win_wdata;
    req_id_t              win_id;
    req_id_t              tag_id;

    assign a_gnt   = a_req & (~b_req | last_b);
    assign b_gnt   = b_req & (~a_req | ~last_b);
    assign any_gnt = a_gnt | b_gnt;

    assign win_id    = b_gnt ? REQ_B : REQ_A;
    assign win_we    = b_gnt ? b_we : a_we;
    assign win_addr  = b_gnt ? b_addr : a_addr;
    assign win_wdata = b_gnt ? b_wdata : a_wdata;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_b <= 1'b1;
        end else if (a_gnt) begin
            last_b <= 1'b0;
        end else if (b_gnt) begin
            last_b <= 1'b1;
        end
    end

    // Address and write data hold across idle cycles; only the strobes drop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ram_blk_select <= 1'b0;
            ram_wr_en      <= 1'b0;
            ram_rd_en      <= 1'b0;
            ram_addr       <= '0;
            ram_din        <= '0;
        end else begin
            ram_blk_select <= any_gnt;
            ram_wr_en      <= any_gnt & win_we;
            ram_rd_en      <= any_gnt & ~win_we;
            if (any_gnt) begin
                ram_addr <= win_addr;
                ram_din  <= win_wdata;
            end
        end
    end

    ram_rd_tag_pipe #(
        .DEPTH (1 + RD_LATENCY)
    ) u_tag_pipe (
        .clk        (clk),
        .rst        (rst),
        .push_valid (any_gnt & ~win_we),
        .push_id    (win_id),
        .tag_valid  (rd_valid),
        .tag_id     (tag_id)
    );

    assign rd_id   = tag_id;
    assign rd_data = ram_dout;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            parity_err <= 1'b0;
        end else if (rd_valid && (ram_parity != ~^ram_dout)) begin
            parity_err <= 1'b1;
        end
    end

    assign ram_addr_en = ~rst;
    assign ram_dout_en = ~rst;

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter with a behavioural pipelined RAM and a read-return scoreboard.
module tb_ram_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        a_req = 1'b0, a_we = 1'b0, b_req = 1'b0, b_we = 1'b0;
    logic [9:0]  a_addr = '0, b_addr = '0;
    logic [15:0] a_wdata = '0, b_wdata = '0;
    logic        a_gnt, b_gnt, rd_valid, rd_id, parity_err;
    logic [15:0] rd_data;
    logic        ram_blk_select, ram_wr_en, ram_rd_en, ram_addr_en, ram_dout_en;
    logic [9:0]  ram_addr;
    logic [15:0] ram_din;
    logic [15:0] ram_dout = '0;
    logic        ram_parity;

    int checks = 0;
    int errors = 0;

    logic [15:0] mem     [1024];
    logic [15:0] exp_mem [1024];
    logic [15:0] ram_s1 = '0;
    logic        parity_force = 1'b0;
    logic [16:0] exp_q[$];

    ram_arbiter dut (
        .clk(clk), .rst(rst),
        .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
        .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
        .a_gnt(a_gnt), .b_gnt(b_gnt),
        .rd_valid(rd_valid), .rd_id(rd_id), .rd_data(rd_data), .parity_err(parity_err),
        .ram_blk_select(ram_blk_select), .ram_wr_en(ram_wr_en), .ram_rd_en(ram_rd_en),
        .ram_addr(ram_addr), .ram_din(ram_din),
        .ram_addr_en(ram_addr_en), .ram_dout_en(ram_dout_en),
        .ram_dout(ram_dout), .ram_parity(ram_parity)
    );

    always #5 clk = ~clk;

    // RAM model: address registered on one edge, output register on the next.
    always @(posedge clk) begin
        if (ram_blk_select && ram_wr_en) mem[ram_addr] <= ram_din;
        if (ram_blk_select && ram_rd_en) ram_s1 <= mem[ram_addr];
        ram_dout <= ram_s1;
    end
    assign ram_parity = parity_force ? 1'b0 : ~^ram_dout;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s obs=%h exp=%h t=%0t", tag, obs, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && rd_valid) begin
            if (exp_q.size() == 0) begin
                chk("rd_unexpected", 32'd1, 32'd0);
            end else begin
                logic [16:0] e;
                e = exp_q.pop_front();
                chk("rd_id", {31'd0, rd_id}, {31'd0, e[16]});
                chk("rd_data", {16'd0, rd_data}, {16'd0, e[15:0]});
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_cmd(input bit is_b, input bit we, input logic [9:0] addr, input logic [15:0] wd);
        if (!is_b) begin
            a_req = 1'b1; a_we = we; a_addr = addr; a_wdata = wd;
        end else begin
            b_req = 1'b1; b_we = we; b_addr = addr; b_wdata = wd;
        end
        #1;
        chk("a_gnt", {31'd0, a_gnt}, {31'd0, !is_b});
        chk("b_gnt", {31'd0, b_gnt}, {31'd0, is_b});
        if (!we) exp_q.push_back({is_b, exp_mem[addr]});
        else exp_mem[addr] = wd;
        step();
        a_req = 1'b0;
        b_req = 1'b0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_ctl"}, {26'd0, ram_blk_select, ram_wr_en, ram_rd_en, ram_addr_en, ram_dout_en, parity_err}, 32'd0);
        chk({tag, "_rd_valid"}, {31'd0, rd_valid}, 32'd0);
        chk({tag, "_rd_id"}, {31'd0, rd_id}, 32'd0);
        chk({tag, "_addr"}, {22'd0, ram_addr}, 32'd0);
        chk({tag, "_din"}, {16'd0, ram_din}, 32'd0);
        chk({tag, "_gnt"}, {30'd0, a_gnt, b_gnt}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog obs=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int a_idx, b_idx;
        for (int i = 0; i < 1024; i++) begin
            mem[i]     = 16'(i) ^ 16'h5A00;
            exp_mem[i] = 16'(i) ^ 16'h5A00;
        end

        // Power-on reset
        #1 rst = 1'b1;
        #2;
        chk_all_zero("por");
        step();
        step();
        chk_all_zero("por_clk");
        rst = 1'b0;
        #1;
        chk("en_after_rst", {30'd0, ram_addr_en, ram_dout_en}, 32'd3);

        // Write 0x1234 @0x005 then read back, latency 3 after the read grant
        do_cmd(0, 1, 10'h005, 16'h1234);
        chk("wr_en_pulse", {31'd0, ram_wr_en}, 32'd1);
        chk("wr_addr", {22'd0, ram_addr}, 32'h005);
        chk("wr_din", {16'd0, ram_din}, 32'h1234);
        do_cmd(0, 0, 10'h005, 16'h0000);
        chk("rd_en_pulse", {31'd0, ram_rd_en}, 32'd1);
        chk("lat_n1", {31'd0, rd_valid}, 32'd0);
        step();
        chk("lat_n2", {31'd0, rd_valid}, 32'd0);
        step();
        chk("lat_n3_valid", {31'd0, rd_valid}, 32'd1);
        chk("lat_n3_id", {31'd0, rd_id}, 32'd0);
        chk("lat_n3_data", {16'd0, rd_data}, 32'h1234);
        step();
        chk("lat_n4", {31'd0, rd_valid}, 32'd0);
        chk("idle_blk", {31'd0, ram_blk_select}, 32'd0);

        // Pointer memory: B alone, then contention starts with A
        do_cmd(1, 0, 10'h050, 16'h0000);
        a_idx = 0;
        b_idx = 0;
        a_req = 1'b1; a_we = 1'b0;
        b_req = 1'b1; b_we = 1'b0;
        for (int i = 0; i < 6; i++) begin
            a_addr = 10'h010 + 10'(a_idx);
            b_addr = 10'h020 + 10'(b_idx);
            #1;
            chk("cont_a_gnt", {31'd0, a_gnt}, {31'd0, (i % 2) == 0});
            chk("cont_b_gnt", {31'd0, b_gnt}, {31'd0, (i % 2) == 1});
            if ((i % 2) == 0) begin
                exp_q.push_back({1'b0, exp_mem[a_addr]});
                a_idx++;
            end else begin
                exp_q.push_back({1'b1, exp_mem[b_addr]});
                b_idx++;
            end
            step();
        end
        a_req = 1'b0;
        b_req = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("cont_stream", {31'd0, rd_valid}, 32'd1);
            step();
        end
        chk("cont_end", {31'd0, rd_valid}, 32'd0);
        step();

        // Four back-to-back B writes: no return strobe
        for (int i = 0; i < 4; i++) begin
            do_cmd(1, 1, 10'h040 + 10'(i), 16'hBEE0 + 16'(i));
            chk("bw_wr_en", {31'd0, ram_wr_en}, 32'd1);
            chk("bw_rd_en", {31'd0, ram_rd_en}, 32'd0);
            chk("bw_addr", {22'd0, ram_addr}, 32'h040 + 32'(i));
            chk("bw_din", {16'd0, ram_din}, 32'hBEE0 + 32'(i));
            chk("bw_no_rd", {31'd0, rd_valid}, 32'd0);
        end
        step();
        chk("bw_wr_end", {31'd0, ram_wr_en}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            chk("bw_quiet", {31'd0, rd_valid}, 32'd0);
            step();
        end
        do_cmd(1, 0, 10'h042, 16'h0000);
        for (int i = 0; i < 4; i++) step();

        // Parity: zero word returned with wrong parity
        do_cmd(0, 1, 10'h030, 16'h0000);
        do_cmd(0, 0, 10'h030, 16'h0000);
        chk("par_before", {31'd0, parity_err}, 32'd0);
        parity_force = 1'b1;
        for (int i = 0; i < 4; i++) step();
        chk("par_set", {31'd0, parity_err}, 32'd1);
        parity_force = 1'b0;
        for (int i = 0; i < 3; i++) step();
        chk("par_sticky", {31'd0, parity_err}, 32'd1);

        // Reset with two reads in flight
        do_cmd(0, 0, 10'h001, 16'h0000);
        do_cmd(0, 0, 10'h002, 16'h0000);
        rst = 1'b1;
        #1;
        chk_all_zero("mid_rst");
        exp_q.delete();
        step();
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("post_rst_rd", {31'd0, rd_valid}, 32'd0);
            chk("post_rst_par", {31'd0, parity_err}, 32'd0);
            step();
        end

        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
